fetch_queue: RTL and testbench

- Small FIFO between the IF stage and the ID stage.
- Buffers {PC, instruction} pairs so that ID-side stalls do not immediately freeze fetch.
- Presents the oldest entry to ID in first-word-fall-through form.
- Drops all contents on a taken branch (flush).

---
 rtl/fetch_queue_pkg.sv | 20 ++
 rtl/fetch_queue_mem.sv | 33 +++
 rtl/fetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the IF->ID fetch queue.
//   FQ_WORD_LEN : width of PC and instruction words
//   FQ_NOP      : instruction encoding presented to ID when nothing is queued
//   FQ_DEPTH    : default number of queue entries
//   fq_op_e     : per-cycle queue operation, used to update the occupancy count
package fetch_queue_pkg;

  localparam int          FQ_WORD_LEN = 32;
  localparam logic [31:0] FQ_NOP      = 32'd0;
  localparam int          FQ_DEPTH    = 4;

  // Bit 1 = pop, bit 0 = push.
  typedef enum logic [1:0] {
    FQ_IDLE = 2'b00,
    FQ_PUSH = 2'b01,
    FQ_POP  = 2'b10,
    FQ_BOTH = 2'b11
  } fq_op_e;

endpackage

// File: rtl/fetch_queue_mem.sv
// Storage array for the fetch queue: DEPTH entries of {PC, instruction}.
// Ports:
//   clk_i   : write clock, rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : {PC, instruction} pair to store
//   raddr_i : read address (combinational read)
//   rdata_o : {PC, instruction} pair at raddr_i
// Storage has no reset; the control logic never exposes an unwritten entry.
module fetch_queue_mem #(
  parameter int WORD_LEN = 32,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [ADDR_W-1:0]       waddr_i,
  input  logic [2*WORD_LEN-1:0]   wdata_i,
  input  logic [ADDR_W-1:0]       raddr_i,
  output logic [2*WORD_LEN-1:0]   rdata_o
);

  logic [2*WORD_LEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between the IF and ID stages. Buffers {PC, instruction} pairs
// and presents the oldest one to ID in first-word-fall-through form.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   flush     : taken branch; discards every queued entry
//   in_valid  : IF presents a fetched pair
//   in_pc     : PC of fetched instruction
//   in_instr  : fetched instruction
//   in_ready  : queue can accept a pair (IF freezes when low)
//   out_ready : ID consumes the head entry this cycle
//   out_valid : head entry is valid
//   out_pc    : PC of head entry (0 when empty)
//   out_instr : instruction of head entry (NOP when empty)
//   count     : current occupancy, 0..DEPTH
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int WORD_LEN = FQ_WORD_LEN,
  parameter int DEPTH    = FQ_DEPTH,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [WORD_LEN-1:0] in_pc,
  input  logic [WORD_LEN-1:0] in_instr,
  output logic                in_ready,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [WORD_LEN-1:0] out_pc,
  output logic [WORD_LEN-1:0] out_instr,
  output logic [CNT_W-1:0]    count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic                  push;
  logic                  pop;
  fq_op_e                op;
  logic [2*WORD_LEN-1:0] head;

  // Handshake flags come from registered count only, so in_ready never
  // depends combinationally on out_ready (a full queue admits no push even
  // when it is popped in the same cycle).
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);

  // Flush wins over both push and pop.
  assign push = in_valid  && in_ready  && !flush;
  assign pop  = out_ready && out_valid && !flush;
  assign op   = fq_op_e'({pop, push});

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case (op)
        FQ_PUSH: count_d = count_q + CNT_W'(1);
        FQ_POP:  count_d = count_q - CNT_W'(1);
        FQ_IDLE,
        FQ_BOTH: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(
    .WORD_LEN (WORD_LEN),
    .DEPTH    (DEPTH),
    .ADDR_W   (PTR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_pc, in_instr}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Empty queue shows a NOP at PC 0 so ID never sees stale storage.
  assign out_pc    = out_valid ? head[2*WORD_LEN-1 -: WORD_LEN] : '0;
  assign out_instr = out_valid ? head[WORD_LEN-1:0] : WORD_LEN'(FQ_NOP);
  assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  in_pc;
  logic [W-1:0]  in_instr;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  out_pc;
  logic [W-1:0]  out_instr;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  // Expected contents of the queue, oldest first: {pc, instr}.
  logic [2*W-1:0] sb[$];
  bit             m_full;
  bit             m_nonempty;

  always #5 clk = ~clk;

  fetch_queue #(.WORD_LEN(W), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus side of the scoreboard: record what the queue must accept/release
  // at each edge, judged from the inputs being offered and the expected state.
  always @(posedge clk) begin
    if (rst) begin
      m_full     = (sb.size() >= DEPTH);
      m_nonempty = (sb.size() != 0);
      if (flush) begin
        sb.delete();
      end else begin
        if (out_ready && m_nonempty) void'(sb.pop_front());
        if (in_valid && !m_full) sb.push_back({in_pc, in_instr});
      end
    end
  end

  // Monitor: mid-cycle compare of DUT outputs against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      check("mon_out_valid", 64'(out_valid), 64'(sb.size() != 0));
      check("mon_count", 64'(count), 64'(sb.size()));
      check("mon_in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
      if (out_valid && sb.size() != 0) begin
        check("mon_head", {out_pc, out_instr}, sb[0]);
      end else if (!out_valid) begin
        check("mon_nop", {out_pc, out_instr}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    #12;
    // Reset state while reset is held.
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_count",     64'(count),     64'd0);
    tick();
    rst = 1'b1;
    tick(); tick();
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_count",     64'(count),     64'd0);

    // Fill to full with ID stalled.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(4*i); in_instr = 32'hA0 + 32'(i);
      tick();
    end
    check("full_count",    64'(count),    64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_pc",   64'(out_pc),   64'd0);
    check("full_out_instr",64'(out_instr),64'hA0);
    in_pc = 32'd16; in_instr = 32'hA4;
    tick();
    check("full_ignore_count", 64'(count), 64'd4);

    // Pop from full: first cycle pop only, next cycle push+pop.
    out_ready = 1'b1;
    tick();
    check("fullpop1_count",  64'(count),  64'd3);
    check("fullpop1_out_pc", 64'(out_pc), 64'd4);
    tick();
    check("fullpop2_count",  64'(count),  64'd3);
    check("fullpop2_out_pc", 64'(out_pc), 64'd8);
    in_valid = 1'b0;
    tick();
    check("drain_pc12", 64'(out_pc), 64'd12);
    tick();
    check("drain_pc16", 64'(out_pc), 64'd16);
    check("drain_instr16", 64'(out_instr), 64'hA4);
    tick();
    check("drain_empty", 64'(out_valid), 64'd0);

    // Streaming at occupancy 1.
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hB00;
    tick();
    check("stream_head0", 64'(out_pc), 64'h100);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_pc = 32'h104 + 32'(4*k); in_instr = 32'hB01 + 32'(k);
      tick();
      check("stream_count", 64'(count), 64'd1);
      check("stream_pc", 64'(out_pc), 64'(32'h104 + 32'(4*k)));
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_count", 64'(count), 64'd0);

    // Flush with a simultaneous push and pop.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h200 + 32'(4*i); in_instr = 32'hC0 + 32'(i);
      tick();
    end
    check("preflush_count", 64'(count), 64'd3);
    flush = 1'b1; out_ready = 1'b1; in_pc = 32'h40; in_instr = 32'hD0;
    tick();
    flush = 1'b0;
    check("flush_count",     64'(count),     64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_instr", 64'(out_instr), 64'd0);
    out_ready = 1'b0; in_pc = 32'h80; in_instr = 32'hD1;
    tick();
    in_valid = 1'b0;
    check("postflush_pc",    64'(out_pc),    64'h80);
    check("postflush_count", 64'(count),     64'd1);
    out_ready = 1'b1;
    tick();
    check("postflush_empty", 64'(out_valid), 64'd0);

    // Wrap-around with occupancy alternating 2/3.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_pc = 32'h300 + 32'(4*i); in_instr = 32'hE0 + 32'(i);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      in_valid  = (k % 2 == 0);
      out_ready = (k % 2 == 1);
      in_pc = 32'h308 + 32'(4*k); in_instr = 32'hE2 + 32'(k);
      tick();
      check("wrap_count", 64'(count), (k % 2 == 0) ? 64'd3 : 64'd2);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (count != 0 && n < 10) begin
      tick();
      n++;
    end
    check("wrap_drained", 64'(count), 64'd0);

    // Asynchronous reset mid-run with 3 entries.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h400 + 32'(4*i); in_instr = 32'hF0 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    check("prerst_count", 64'(count), 64'd3);
    #1;
    rst = 1'b0;
    sb.delete();
    #1;
    check("async_rst_count",     64'(count),     64'd0);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_out_pc",    64'(out_pc),    64'd0);
    tick();
    rst = 1'b1;
    in_valid = 1'b1; in_pc = 32'h500; in_instr = 32'h55;
    tick();
    in_valid = 1'b0;
    check("after_rst_pc",    64'(out_pc),    64'h500);
    check("after_rst_count", 64'(count),     64'd1);
    out_ready = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
